// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D cache memory arbiter.
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } own_e;

   localparam int BLK_OFF_W = 4;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant choice between I-side and D-side requests.
// MEM_ARB_RR_EN adds the round-robin pointer; otherwise D wins.
module arb_pick
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic clk,
   input  logic rst_n,
   input  logic take_i,
`endif
   input  logic i_req_i,
   input  logic d_req_i,
   output own_e own_o,
   output logic gnt_o
);

   assign gnt_o = i_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
   own_e ptr_q;
   own_e ptr_d;

   // The side that loses a contended grant gets the next one.
   always_comb begin
      ptr_d = ptr_q;
      if (take_i && i_req_i && d_req_i)
         ptr_d = (own_o == OWN_D) ? OWN_I : OWN_D;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= OWN_D;
      else        ptr_q <= ptr_d;
   end

   always_comb begin
      own_o = OWN_D;
      if (i_req_i && d_req_i) own_o = ptr_q;
      else if (i_req_i)       own_o = OWN_I;
   end
`else
   always_comb begin
      own_o = OWN_D;
      if (i_req_i && !d_req_i) own_o = OWN_I;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares main memory between I-cache fills and D-cache fills/stores.
// Define MEM_ARB_RR_EN for round-robin instead of D-side priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WORDS   = 8,
   parameter int MEM_LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_valid,
   output logic [15:0] fill_data,
   output logic [2:0]  fill_word,
   output logic        i_fill_we,
   output logic        d_fill_we,
   output logic        i_done,
   output logic        d_done,
   output logic        busy
);

   localparam int WIDX = $clog2(WORDS);
   localparam logic [3:0] WORDS_C = 4'(WORDS);
   localparam logic [3:0] LAST_C  = 4'(WORDS - 1);

   if (WORDS != (1 << WIDX)) begin : g_words_chk
      $error("WORDS must be a power of two");
   end
   if (WIDX + 1 != BLK_OFF_W) begin : g_blk_chk
      $error("WORDS must match the 16-byte block");
   end
   if (MEM_LAT < 1) begin : g_lat_chk
      $error("MEM_LAT must be at least 1");
   end

   state_e      state_q;
   own_e        own_q;
   logic [3:0]  issue_q;
   logic [3:0]  recv_q;
   logic [11:0] blk_q;
   logic [11:0] blk_d;

   own_e pick;
   logic gnt;
   logic take;

   assign take = (state_q == IDLE) && gnt;

   arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
      .clk     (clk),
      .rst_n   (rst_n),
      .take_i  (take),
`endif
      .i_req_i (i_req),
      .d_req_i (d_req),
      .own_o   (pick),
      .gnt_o   (gnt)
   );

   assign blk_d = (pick == OWN_D) ? d_addr[15:BLK_OFF_W]
                                  : i_addr[15:BLK_OFF_W];

   logic unused_addr_bits;
   assign unused_addr_bits = ^i_addr[BLK_OFF_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         own_q   <= OWN_D;
         issue_q <= '0;
         recv_q  <= '0;
         blk_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (take) begin
                  own_q <= pick;
                  if (pick == OWN_D && d_we) begin
                     state_q <= WR;
                  end else begin
                     state_q <= FILL;
                     issue_q <= '0;
                     recv_q  <= '0;
                     blk_q   <= blk_d;
                  end
               end
            end
            WR: state_q <= DONE;
            FILL: begin
               if (issue_q < WORDS_C) issue_q <= issue_q + 4'd1;
               if (mem_valid) begin
                  if (recv_q < WORDS_C) recv_q <= recv_q + 4'd1;
                  if (recv_q == LAST_C) state_q <= DONE;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fill_data = mem_rdata;
   assign busy      = (state_q != IDLE);

   always_comb begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      fill_word = '0;
      i_fill_we = 1'b0;
      d_fill_we = 1'b0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      unique case (state_q)
         WR: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
         end
         FILL: begin
            if (issue_q < WORDS_C) begin
               mem_en   = 1'b1;
               mem_addr = {blk_q, issue_q[WIDX-1:0], 1'b0};
            end
            if (mem_valid) begin
               fill_word = recv_q[WIDX-1:0];
               i_fill_we = (own_q == OWN_I);
               d_fill_we = (own_q == OWN_D);
            end
         end
         DONE: begin
            i_done = (own_q == OWN_I);
            d_done = (own_q == OWN_D);
         end
         default: ;
      endcase
   end

endmodule
